seq_ctrl: RTL and testbench

- Parametrised instruction sequencer for the CPU control path.
- Walks a fixed per-opcode micro-step table and emits one `STATE_*` code per cycle; datapath decoders consume it unchanged.
- Single-edge (posedge only) successor to the current mixed-edge sequencer.
- Adds a memory wait handshake, halt/resume, a sticky illegal-opcode flag, a step-overflow watchdog and an optional interrupt entry sequence.

---
 rtl/seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// seq_ctrl: table-driven instruction sequencer for the CPU control path.
// Emits one micro-state code per cycle, stepping through a fixed per-opcode
// micro-step table. Includes memory wait states, halt/resume, a sticky
// illegal-opcode flag and a step-overflow watchdog.
// Optional interrupt entry sequence: define SEQ_CTRL_IRQ_EN to enable it.
module seq_ctrl #(
    parameter int OPCODE_W  = 8,
    parameter int STATE_W   = 8,
    parameter int STEP_W    = 4,
    parameter int MAX_STEPS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                resume,
    input  logic                irq_req,
    output logic [STATE_W-1:0]  state,
    output logic [STEP_W-1:0]   step,
    output logic                inst_done,
    output logic                halted,
    output logic                illegal,
    output logic                overrun,
    output logic                irq_ack
);

    // Micro-state codes; exported zero-extended to STATE_W.
    typedef enum logic [4:0] {
        ST_NEXT       = 5'd0,
        ST_FETCH_PC   = 5'd1,
        ST_FETCH_INST = 5'd2,
        ST_HALT       = 5'd3,
        ST_MOVE_REG   = 5'd4,
        ST_SET_REG    = 5'd5,
        ST_LOAD_ADDR  = 5'd6,
        ST_SET_MEM    = 5'd7,
        ST_ALU_EXEC   = 5'd8,
        ST_ALU_OUT    = 5'd9,
        ST_FETCH_SP   = 5'd10,
        ST_STACK_REG  = 5'd11,
        ST_INC_SP     = 5'd12,
        ST_JUMP       = 5'd13,
        ST_STORE_PC   = 5'd14,
        ST_TMP_JUMP   = 5'd15,
        ST_RET        = 5'd16,
        ST_MOUT_STORE = 5'd17,
        ST_ROUT_STORE = 5'd18,
        ST_SET_MAR    = 5'd19
    } st_t;

    // Opcode map, zero-extended to OPCODE_W.
    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(8'h03);
    localparam logic [OPCODE_W-1:0] OP_LDX  = OPCODE_W'(8'h04);
    localparam logic [OPCODE_W-1:0] OP_STX  = OPCODE_W'(8'h05);
    localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(8'h06);
    localparam logic [OPCODE_W-1:0] OP_ALU  = OPCODE_W'(8'h07);
    localparam logic [OPCODE_W-1:0] OP_PUSH = OPCODE_W'(8'h08);
    localparam logic [OPCODE_W-1:0] OP_POP  = OPCODE_W'(8'h09);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(8'h0A);
    localparam logic [OPCODE_W-1:0] OP_CALL = OPCODE_W'(8'h0B);
    localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(8'h0C);
    localparam logic [OPCODE_W-1:0] OP_MOUT = OPCODE_W'(8'h0D);
    localparam logic [OPCODE_W-1:0] OP_ROUT = OPCODE_W'(8'h0E);
    localparam logic [OPCODE_W-1:0] OP_LDA  = OPCODE_W'(8'h0F);
    localparam logic [OPCODE_W-1:0] OP_STA  = OPCODE_W'(8'h10);

    // Step indices used by the micro-step table.
    localparam logic [STEP_W-1:0] S0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] S1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] S2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] S3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] S4 = STEP_W'(4);
    localparam logic [STEP_W-1:0] S5 = STEP_W'(5);
    localparam logic [STEP_W-1:0] S6 = STEP_W'(6);
    // One extra bit so a limit equal to 2^STEP_W does not alias to zero.
    localparam logic [STEP_W:0]   WD_LIMIT = (STEP_W+1)'(MAX_STEPS);

    // Memory-access states that stall while mem_ready is low.
    function automatic logic is_wait(input st_t st);
        case (st)
            ST_FETCH_INST, ST_LOAD_ADDR, ST_SET_MEM, ST_MOUT_STORE: is_wait = 1'b1;
            default:                                               is_wait = 1'b0;
        endcase
    endfunction

    // True for every opcode present in the micro-step table.
    function automatic logic op_known(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_NOP, OP_HLT, OP_MOV, OP_LDI, OP_LDX, OP_STX, OP_CMP, OP_ALU, OP_PUSH,
            OP_POP, OP_JMP, OP_CALL, OP_RET, OP_MOUT, OP_ROUT, OP_LDA, OP_STA: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    endfunction

    // Micro-step table: state entered when leaving table index idx.
    // Index 2 onward is the opcode-specific body; past its end the entry is NEXT.
    function automatic st_t seq_entry(input logic [OPCODE_W-1:0] op, input logic [STEP_W-1:0] idx);
        st_t e;
        if (idx == S0) begin
            e = ST_FETCH_PC;
        end else if (idx == S1) begin
            e = ST_FETCH_INST;
        end else begin
            case (op)
                OP_HLT:  case (idx) S2: e = ST_HALT;       default: e = ST_NEXT; endcase
                OP_MOV:  case (idx) S2: e = ST_MOVE_REG;   default: e = ST_NEXT; endcase
                OP_LDI:  case (idx) S2: e = ST_FETCH_PC;   S3: e = ST_SET_REG;   default: e = ST_NEXT; endcase
                OP_LDX:  case (idx) S2: e = ST_FETCH_PC;   S3: e = ST_LOAD_ADDR; S4: e = ST_SET_REG;    default: e = ST_NEXT; endcase
                OP_STX:  case (idx) S2: e = ST_FETCH_PC;   S3: e = ST_LOAD_ADDR; S4: e = ST_SET_MEM;    default: e = ST_NEXT; endcase
                OP_CMP:  case (idx) S2: e = ST_ALU_EXEC;   default: e = ST_NEXT; endcase
                OP_ALU:  case (idx) S2: e = ST_ALU_EXEC;   S3: e = ST_ALU_OUT;   default: e = ST_NEXT; endcase
                OP_PUSH: case (idx) S2: e = ST_FETCH_SP;   S3: e = ST_STACK_REG; default: e = ST_NEXT; endcase
                OP_POP:  case (idx) S2: e = ST_INC_SP;     S3: e = ST_FETCH_SP;  S4: e = ST_SET_REG;    default: e = ST_NEXT; endcase
                OP_JMP:  case (idx) S2: e = ST_FETCH_PC;   S3: e = ST_JUMP;      default: e = ST_NEXT; endcase
                OP_CALL: case (idx) S2: e = ST_FETCH_PC;   S3: e = ST_SET_REG;   S4: e = ST_FETCH_PC;
                                    S5: e = ST_STORE_PC;   S6: e = ST_TMP_JUMP;  default: e = ST_NEXT; endcase
                OP_RET:  case (idx) S2: e = ST_INC_SP;     S3: e = ST_FETCH_SP;  S4: e = ST_RET;        default: e = ST_NEXT; endcase
                OP_MOUT: case (idx) S2: e = ST_FETCH_PC;   S3: e = ST_LOAD_ADDR; S4: e = ST_MOUT_STORE; default: e = ST_NEXT; endcase
                OP_ROUT: case (idx) S2: e = ST_ROUT_STORE; default: e = ST_NEXT; endcase
                OP_LDA:  case (idx) S2: e = ST_SET_MAR;    S3: e = ST_SET_REG;   default: e = ST_NEXT; endcase
                OP_STA:  case (idx) S2: e = ST_SET_MAR;    S3: e = ST_SET_MEM;   default: e = ST_NEXT; endcase
                default: e = ST_NEXT;
            endcase
        end
        seq_entry = e;
    endfunction

    // Interrupt entry body: FETCH_SP (step 1), STORE_PC, TMP_JUMP, then NEXT.
    function automatic st_t irq_entry(input logic [STEP_W-1:0] idx);
        case (idx)
            S1:      irq_entry = ST_STORE_PC;
            S2:      irq_entry = ST_TMP_JUMP;
            default: irq_entry = ST_NEXT;
        endcase
    endfunction

    st_t                 state_r, state_nxt;
    logic [STEP_W-1:0]   step_r, step_nxt;
    logic [OPCODE_W-1:0] opcode_q_r, opcode_nxt;
    logic                inst_done_r, halted_r, illegal_r, overrun_r;
    logic                illegal_set_s, overrun_set_s, wd_hit_s;
    logic                irq_take_s, irq_seq_s, irq_enter_s, ret_done_s;

    assign wd_hit_s = ({1'b0, step_r} == WD_LIMIT) && (state_r != ST_NEXT) && (state_r != ST_HALT);

    // Next-state, step and flag-set decisions for the coming edge.
    always_comb begin
        state_nxt     = state_r;
        step_nxt      = step_r;
        opcode_nxt    = opcode_q_r;
        illegal_set_s = 1'b0;
        overrun_set_s = 1'b0;
        irq_enter_s   = 1'b0;
        ret_done_s    = 1'b0;
        if (wd_hit_s) begin
            state_nxt     = ST_NEXT;
            step_nxt      = S0;
            overrun_set_s = 1'b1;
        end else if (state_r == ST_HALT) begin
            // A takeable interrupt wakes the core just like resume.
            if (resume || irq_take_s) begin
                state_nxt = ST_NEXT;
                step_nxt  = S0;
            end else begin
                state_nxt = ST_HALT;
            end
        end else if (is_wait(state_r) && !mem_ready) begin
            state_nxt = state_r;
        end else if (state_r == ST_NEXT) begin
            step_nxt = S1;
            if (irq_take_s) begin
                state_nxt   = ST_FETCH_SP;
                irq_enter_s = 1'b1;
            end else begin
                state_nxt = ST_FETCH_PC;
            end
        end else if (irq_seq_s) begin
            state_nxt = irq_entry(step_r);
            step_nxt  = (state_nxt == ST_NEXT) ? S0 : step_r + S1;
        end else begin
            // Step 2 decodes the live opcode and captures it for later steps.
            if (step_r == S2) begin
                opcode_nxt    = opcode;
                illegal_set_s = !op_known(opcode);
                state_nxt     = seq_entry(opcode, step_r);
            end else begin
                state_nxt = seq_entry(opcode_q_r, step_r);
            end
            step_nxt   = (state_nxt == ST_NEXT) ? S0 : step_r + S1;
            ret_done_s = (state_r == ST_RET) && (state_nxt == ST_NEXT);
        end
    end

    // Sequencer state register and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_NEXT;
            step_r      <= S0;
            opcode_q_r  <= {OPCODE_W{1'b0}};
            inst_done_r <= 1'b0;
            halted_r    <= 1'b0;
            illegal_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            step_r      <= step_nxt;
            opcode_q_r  <= opcode_nxt;
            inst_done_r <= (state_nxt == ST_NEXT) && (state_r != ST_NEXT);
            halted_r    <= (state_nxt == ST_HALT);
            illegal_r   <= illegal_r | illegal_set_s;
            overrun_r   <= overrun_r | overrun_set_s;
        end
    end

`ifdef SEQ_CTRL_IRQ_EN
    logic irq_mask_r, irq_seq_r, irq_ack_r;

    assign irq_take_s = irq_req && !irq_mask_r;
    assign irq_seq_s  = irq_seq_r;
    assign irq_ack    = irq_ack_r;

    // Interrupt mask (no nesting until RET), entry-sequence flag and ack pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask_r <= 1'b0;
            irq_seq_r  <= 1'b0;
            irq_ack_r  <= 1'b0;
        end else begin
            irq_ack_r <= irq_enter_s;
            if (irq_enter_s) begin
                irq_mask_r <= 1'b1;
            end else if (ret_done_s) begin
                irq_mask_r <= 1'b0;
            end else begin
                irq_mask_r <= irq_mask_r;
            end
            if (irq_enter_s) begin
                irq_seq_r <= 1'b1;
            end else if (state_nxt == ST_NEXT) begin
                irq_seq_r <= 1'b0;
            end else begin
                irq_seq_r <= irq_seq_r;
            end
        end
    end
`else
    logic unused_irq_s;

    assign irq_take_s   = 1'b0;
    assign irq_seq_s    = 1'b0;
    assign irq_ack      = 1'b0;
    assign unused_irq_s = ^{irq_req, irq_enter_s, ret_done_s};
`endif

    assign state     = STATE_W'(state_r);
    assign step      = step_r;
    assign inst_done = inst_done_r;
    assign halted    = halted_r;
    assign illegal   = illegal_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed stimulus for seq_ctrl with a queue-based scoreboard.
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares.
module tb_seq_ctrl;

    localparam logic [7:0] S_NEXT = 8'd0,  S_FETCH_PC = 8'd1,  S_FETCH_INST = 8'd2, S_HALT = 8'd3;
    localparam logic [7:0] S_MOVE_REG = 8'd4, S_SET_REG = 8'd5, S_LOAD_ADDR = 8'd6, S_SET_MEM = 8'd7;
    localparam logic [7:0] S_ALU_EXEC = 8'd8, S_ALU_OUT = 8'd9, S_FETCH_SP = 8'd10, S_STACK_REG = 8'd11;
    localparam logic [7:0] S_INC_SP = 8'd12, S_JUMP = 8'd13, S_STORE_PC = 8'd14, S_TMP_JUMP = 8'd15;
    localparam logic [7:0] S_RET = 8'd16, S_MOUT_STORE = 8'd17, S_ROUT_STORE = 8'd18, S_SET_MAR = 8'd19;

    localparam logic [7:0] OP_NOP = 8'h00, OP_HLT = 8'h01, OP_MOV = 8'h02, OP_LDI = 8'h03;
    localparam logic [7:0] OP_LDX = 8'h04, OP_STX = 8'h05, OP_CMP = 8'h06, OP_ALU = 8'h07;
    localparam logic [7:0] OP_PUSH = 8'h08, OP_POP = 8'h09, OP_JMP = 8'h0A, OP_CALL = 8'h0B;
    localparam logic [7:0] OP_RET = 8'h0C, OP_MOUT = 8'h0D, OP_ROUT = 8'h0E, OP_LDA = 8'h0F;
    localparam logic [7:0] OP_STA = 8'h10, OP_BAD = 8'hEE;

    logic       clk = 1'b0;
    logic       reset, mem_ready, resume, irq_req;
    logic [7:0] opcode;
    logic [7:0] state;
    logic [3:0] step;
    logic       inst_done, halted, illegal, overrun, irq_ack;

    always #5 clk = ~clk;

    seq_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .resume(resume), .irq_req(irq_req), .state(state), .step(step),
        .inst_done(inst_done), .halted(halted), .illegal(illegal),
        .overrun(overrun), .irq_ack(irq_ack)
    );

    typedef struct packed {
        logic [95:0] tag;
        logic [7:0]  st;
        logic [3:0]  stp;
        logic [4:0]  flg;   // {inst_done, halted, illegal, overrun, irq_ack}
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;
    logic ill_exp = 1'b0;

    // Queue the outputs expected after the next rising edge, then advance.
    task automatic tick(input logic [95:0] tag, input logic [7:0] st, input logic [3:0] stp,
                        input logic done, input logic ack);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.stp = stp;
        e.flg = {done, (st == S_HALT), ill_exp, 1'b0, ack};
        q.push_back(e);
        @(negedge clk);
    endtask

    // One instruction from NEXT: fetch, body states (MSB-first in body), back to NEXT.
    task automatic run_seq(input logic [95:0] tag, input logic [7:0] op, input logic [47:0] body,
                           input int n, input logic bad);
        opcode = op;
        tick(tag, S_FETCH_PC, 4'd1, 1'b0, 1'b0);
        tick(tag, S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            tick(tag, body[47-8*k -: 8], 4'(3 + k), 1'b0, 1'b0);
        end
        if (bad) ill_exp = 1'b1;
        tick(tag, S_NEXT, 4'd0, 1'b1, 1'b0);
    endtask

    // Monitor: compare every cycle for which an expectation is queued.
    always begin
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            m = q.pop_front();
            checks++;
            if (state !== m.st || step !== m.stp ||
                {inst_done, halted, illegal, overrun, irq_ack} !== m.flg) begin
                errors++;
                $display("FAIL %s: got state=%0d step=%0d flags=%b, want state=%0d step=%0d flags=%b",
                         m.tag, state, step, {inst_done, halted, illegal, overrun, irq_ack},
                         m.st, m.stp, m.flg);
            end
        end
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; resume = 1'b0; irq_req = 1'b0; opcode = OP_NOP;
        @(negedge clk);
        repeat (3) tick("reset", S_NEXT, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;

        run_seq("nop",  OP_NOP,  48'h0, 0, 1'b0);
        run_seq("call", OP_CALL, {S_FETCH_PC, S_SET_REG, S_FETCH_PC, S_STORE_PC, S_TMP_JUMP, 8'h00}, 5, 1'b0);
        run_seq("mov",  OP_MOV,  {S_MOVE_REG, 40'h0}, 1, 1'b0);
        run_seq("ldi",  OP_LDI,  {S_FETCH_PC, S_SET_REG, 32'h0}, 2, 1'b0);
        run_seq("ldx",  OP_LDX,  {S_FETCH_PC, S_LOAD_ADDR, S_SET_REG, 24'h0}, 3, 1'b0);
        run_seq("cmp",  OP_CMP,  {S_ALU_EXEC, 40'h0}, 1, 1'b0);
        run_seq("alu",  OP_ALU,  {S_ALU_EXEC, S_ALU_OUT, 32'h0}, 2, 1'b0);
        run_seq("push", OP_PUSH, {S_FETCH_SP, S_STACK_REG, 32'h0}, 2, 1'b0);
        run_seq("pop",  OP_POP,  {S_INC_SP, S_FETCH_SP, S_SET_REG, 24'h0}, 3, 1'b0);
        run_seq("jmp",  OP_JMP,  {S_FETCH_PC, S_JUMP, 32'h0}, 2, 1'b0);
        run_seq("ret",  OP_RET,  {S_INC_SP, S_FETCH_SP, S_RET, 24'h0}, 3, 1'b0);
        run_seq("mout", OP_MOUT, {S_FETCH_PC, S_LOAD_ADDR, S_MOUT_STORE, 24'h0}, 3, 1'b0);
        run_seq("rout", OP_ROUT, {S_ROUT_STORE, 40'h0}, 1, 1'b0);
        run_seq("lda",  OP_LDA,  {S_SET_MAR, S_SET_REG, 32'h0}, 2, 1'b0);
        run_seq("sta",  OP_STA,  {S_SET_MAR, S_SET_MEM, 32'h0}, 2, 1'b0);

        // STX with a 3-cycle stall in SET_MEM; the opcode change must not matter.
        opcode = OP_STX;
        tick("stx", S_FETCH_PC, 4'd1, 1'b0, 1'b0);
        tick("stx", S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        tick("stx", S_FETCH_PC, 4'd3, 1'b0, 1'b0);
        tick("stx", S_LOAD_ADDR, 4'd4, 1'b0, 1'b0);
        tick("stx", S_SET_MEM, 4'd5, 1'b0, 1'b0);
        mem_ready = 1'b0;
        opcode = OP_NOP;
        repeat (3) tick("stx_stall", S_SET_MEM, 4'd5, 1'b0, 1'b0);
        mem_ready = 1'b1;
        tick("stx_end", S_NEXT, 4'd0, 1'b1, 1'b0);

        // mem_ready low: FETCH_PC is not a wait state, FETCH_INST is.
        opcode = OP_LDI;
        mem_ready = 1'b0;
        tick("ldi_wait", S_FETCH_PC, 4'd1, 1'b0, 1'b0);
        tick("ldi_wait", S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        tick("ldi_wait", S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        mem_ready = 1'b1;
        tick("ldi_wait", S_FETCH_PC, 4'd3, 1'b0, 1'b0);
        tick("ldi_wait", S_SET_REG, 4'd4, 1'b0, 1'b0);
        tick("ldi_wait", S_NEXT, 4'd0, 1'b1, 1'b0);

        // HLT: hold in HALT with step frozen until resume.
        opcode = OP_HLT;
        tick("hlt", S_FETCH_PC, 4'd1, 1'b0, 1'b0);
        tick("hlt", S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        tick("hlt", S_HALT, 4'd3, 1'b0, 1'b0);
        repeat (10) tick("hlt_hold", S_HALT, 4'd3, 1'b0, 1'b0);
        resume = 1'b1;
        tick("hlt_resume", S_NEXT, 4'd0, 1'b1, 1'b0);
        resume = 1'b0;

`ifndef SEQ_CTRL_IRQ_EN
        irq_req = 1'b1;
        run_seq("irq_off", OP_NOP, 48'h0, 0, 1'b0);
        irq_req = 1'b0;
`endif

        // Undefined opcode: illegal sets and sticks across valid instructions.
        run_seq("bad",      OP_BAD,  48'h0, 0, 1'b1);
        run_seq("bad_nop",  OP_NOP,  48'h0, 0, 1'b0);
        run_seq("bad_call", OP_CALL, {S_FETCH_PC, S_SET_REG, S_FETCH_PC, S_STORE_PC, S_TMP_JUMP, 8'h00}, 5, 1'b0);

        // Reset mid-sequence clears everything, no done pulse.
        opcode = OP_LDX;
        tick("rst_mid", S_FETCH_PC, 4'd1, 1'b0, 1'b0);
        tick("rst_mid", S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        tick("rst_mid", S_FETCH_PC, 4'd3, 1'b0, 1'b0);
        reset = 1'b0;
        ill_exp = 1'b0;
        tick("rst_mid", S_NEXT, 4'd0, 1'b0, 1'b0);
        tick("rst_mid", S_NEXT, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        run_seq("post_rst", OP_NOP, 48'h0, 0, 1'b0);

`ifdef SEQ_CTRL_IRQ_EN
        // Interrupt entry, masked second request, unmask on RET.
        irq_req = 1'b1;
        tick("irq", S_FETCH_SP, 4'd1, 1'b0, 1'b1);
        tick("irq", S_STORE_PC, 4'd2, 1'b0, 1'b0);
        tick("irq", S_TMP_JUMP, 4'd3, 1'b0, 1'b0);
        tick("irq", S_NEXT, 4'd0, 1'b1, 1'b0);
        run_seq("irq_masked", OP_NOP, 48'h0, 0, 1'b0);
        run_seq("irq_ret", OP_RET, {S_INC_SP, S_FETCH_SP, S_RET, 24'h0}, 3, 1'b0);
        tick("irq2", S_FETCH_SP, 4'd1, 1'b0, 1'b1);
        tick("irq2", S_STORE_PC, 4'd2, 1'b0, 1'b0);
        tick("irq2", S_TMP_JUMP, 4'd3, 1'b0, 1'b0);
        tick("irq2", S_NEXT, 4'd0, 1'b1, 1'b0);
        irq_req = 1'b0;
        run_seq("irq_ret2", OP_RET, {S_INC_SP, S_FETCH_SP, S_RET, 24'h0}, 3, 1'b0);
        // A pending interrupt wakes HALT, then is taken at NEXT.
        opcode = OP_HLT;
        tick("irq_hlt", S_FETCH_PC, 4'd1, 1'b0, 1'b0);
        tick("irq_hlt", S_FETCH_INST, 4'd2, 1'b0, 1'b0);
        tick("irq_hlt", S_HALT, 4'd3, 1'b0, 1'b0);
        tick("irq_hlt", S_HALT, 4'd3, 1'b0, 1'b0);
        irq_req = 1'b1;
        tick("irq_wake", S_NEXT, 4'd0, 1'b1, 1'b0);
        tick("irq_wake", S_FETCH_SP, 4'd1, 1'b0, 1'b1);
        irq_req = 1'b0;
        tick("irq_wake", S_STORE_PC, 4'd2, 1'b0, 1'b0);
        tick("irq_wake", S_TMP_JUMP, 4'd3, 1'b0, 1'b0);
        tick("irq_wake", S_NEXT, 4'd0, 1'b1, 1'b0);
`endif

        // Let the monitor drain the last expectation.
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d queued expectations, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
